uart_tx_arb: RTL

Frame-level round-robin arbiter that shares the single UART transmit byte path between two requesters: the button-driven transmit block and the receive/echo block. Each requester presents bytes on a valid/ready interface with an end-of-frame flag. The arbiter grants one requester for a whole frame and forwards its bytes to the downstream UART byte transmitter. It sits in the 125 MHz `clk` domain between the two requesters and the UART serializer that drives `uart_tx`.

---
 rtl/uart_tx_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: frame-level round-robin arbiter sharing the UART transmit byte
// path between two valid/ready requesters. A grant is held for a whole frame
// (until a transfer with last=1). Byte forwarding is combinational from the
// granted requester. Optional stall timeout is enabled with the macro
// UART_TX_ARB_TIMEOUT_EN; without it o_timeout is tied low.
module uart_tx_arb #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1250000,
  parameter int unsigned CNT_W       = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [1:0]        o_grant,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  // Elaboration guard: the stall counter must be able to hold TIMEOUT_CYC-1.
  if (64'(TIMEOUT_CYC) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("uart_tx_arb: CNT_W too narrow for TIMEOUT_CYC");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_srv;
  logic       last_srv_nxt;
  logic       xfer;
  logic       xfer_last;
  logic       fire;

  // Forward the granted requester to the serializer; everything idle otherwise.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer_last  = 1'b0;
    case (state)
      GNT0: begin
        tx_valid   = req0_valid;
        tx_data    = req0_data;
        req0_ready = tx_ready;
        xfer_last  = req0_last;
      end
      GNT1: begin
        tx_valid   = req1_valid;
        tx_data    = req1_data;
        req1_ready = tx_ready;
        xfer_last  = req1_last;
      end
      default: ;
    endcase
  end

  assign xfer      = tx_valid & tx_ready;
  assign o_grant   = {state == GNT1, state == GNT0};
  assign o_busy    = (state != IDLE);
  assign o_timeout = fire;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] stall_cnt;

  // Forced release only when no byte moves this cycle; a last byte wins.
  assign fire = o_busy & ~xfer & (stall_cnt == CNT_MAX);

  // Stall counter: cleared in IDLE, on transfers and on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!o_busy || xfer || fire) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign fire = 1'b0;
`endif

  // Next-state and last-served pointer logic.
  always_comb begin
    state_nxt    = state;
    last_srv_nxt = last_srv;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          if (last_srv) begin
            state_nxt    = GNT0;
            last_srv_nxt = 1'b0;
          end else begin
            state_nxt    = GNT1;
            last_srv_nxt = 1'b1;
          end
        end else if (req0_valid) begin
          state_nxt    = GNT0;
          last_srv_nxt = 1'b0;
        end else if (req1_valid) begin
          state_nxt    = GNT1;
          last_srv_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if ((xfer && xfer_last) || fire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset; pointer resets so req0 wins first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_srv <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_srv <= last_srv_nxt;
    end
  end

endmodule
